// File: rtl/n64_bus_router_pkg.sv
// n64_bus_pkg: shared types and constants for the N64 bus router.
//   e_bank         - symbolic names for the 4-bit bank index (bank 0 is unmapped)
//   e_router_state - transaction FSM states
//   UNMAPPED_READ_DATA / TIMEOUT_READ_DATA - read data returned on locally
//                    terminated transactions
package n64_bus_pkg;

    typedef enum logic [3:0] {
        BANK_INVALID = 4'd0,
        BANK_SDRAM   = 4'd1,
        BANK_CART    = 4'd2,
        BANK_EEPROM  = 4'd3,
        BANK_FLASH   = 4'd4,
        BANK_SD      = 4'd5,
        BANK_DDIPL   = 4'd6,
        BANK_CONFIG  = 4'd7
    } e_bank;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } e_router_state;

    localparam logic [31:0] UNMAPPED_READ_DATA = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_READ_DATA  = 32'hFFFF_FFFF;

endpackage

// File: rtl/n64_bus_router_if.sv
// n64_bus_router_if: upstream PI transaction bus plus device-side request
// fan-out, bundled for the router.
//   slave  - the router: consumes i_* signals, drives o_* signals
//   master - the environment (PI front-end and devices): the reverse
// Parameter NUM_BANKS sizes the per-device vectors; i_device_data slice b
// is bits [32*b+31:32*b].
interface n64_bus_router_if #(
    parameter int NUM_BANKS = 8
);
    // Upstream (PI) side
    logic                      i_request;
    logic                      i_write;
    logic [3:0]                i_bank;
    logic [25:0]               i_address;
    logic [31:0]               i_data;
    logic                      o_busy;
    logic                      o_ack;
    logic [31:0]               o_data;
    logic                      o_timeout;

    // Device side
    logic [NUM_BANKS-1:0]      o_device_request;
    logic                      o_device_write;
    logic [25:0]               o_device_address;
    logic [31:0]               o_device_data;
    logic [NUM_BANKS-1:0]      i_device_busy;
    logic [NUM_BANKS-1:0]      i_device_ack;
    logic [32*NUM_BANKS-1:0]   i_device_data;

    modport slave (
        input  i_request, i_write, i_bank, i_address, i_data,
        input  i_device_busy, i_device_ack, i_device_data,
        output o_busy, o_ack, o_data, o_timeout,
        output o_device_request, o_device_write, o_device_address, o_device_data
    );

    modport master (
        output i_request, i_write, i_bank, i_address, i_data,
        output i_device_busy, i_device_ack, i_device_data,
        input  o_busy, o_ack, o_data, o_timeout,
        input  o_device_request, o_device_write, o_device_address, o_device_data
    );

endinterface

// File: rtl/n64_bus_router.sv
// n64_bus_router: routes the PI front-end's single outstanding transaction to
// one of NUM_BANKS devices and returns a one-cycle ack plus read data.
// Bank 0 and banks >= NUM_BANKS are terminated locally (o_data = 0).
//
// Ports:
//   i_clk   - system clock, rising edge
//   i_reset - synchronous, active-high reset
//   bus     - n64_bus_router_if.slave: upstream request/ack/data and the
//             device-side one-hot request, busy/ack handshake and read data
//
// Optional feature macro: N64_BUS_TIMEOUT_EN
//   Adds a watchdog that aborts a device transaction after TIMEOUT_CYCLES,
//   returning TIMEOUT_READ_DATA for reads and pulsing o_timeout with o_ack.
//   Without it o_timeout is tied low and the router waits indefinitely.
module n64_bus_router
    import n64_bus_pkg::*;
#(
    parameter int NUM_BANKS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    n64_bus_router_if.slave    bus
);

    e_router_state          state_q, state_d;
    logic [NUM_BANKS-1:0]   sel_q, sel_d;       // one-hot target device, 0 when unmapped
    logic                   dev_write_q, dev_write_d;
    logic [25:0]            dev_addr_q, dev_addr_d;
    logic [31:0]            dev_data_q, dev_data_d;
    logic [31:0]            data_q, data_d;

    logic [NUM_BANKS-1:0]   decoded;
    logic                   sel_busy;
    logic                   sel_ack;
    logic [31:0]            sel_rdata;

    // Bank decode; bit 0 is never set, so unmapped banks decode to all zeros.
    always_comb begin
        decoded = '0;
        for (int b = 1; b < NUM_BANKS; b++) begin
            if (bus.i_bank == 4'(b)) decoded[b] = 1'b1;
        end
    end

    // Selected device's handshake and data, masked by the one-hot select so
    // activity on other banks is ignored.
    always_comb begin
        sel_busy  = |(bus.i_device_busy & sel_q);
        sel_ack   = |(bus.i_device_ack & sel_q);
        sel_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel_q[b]) sel_rdata = bus.i_device_data[32*b +: 32];
        end
    end

`ifdef N64_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    // The watchdog limit only matters when the watchdog is built in.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    // NOTE: every signal gets a default before the case statement so no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dev_write_d = dev_write_q;
        dev_addr_d  = dev_addr_q;
        dev_data_d  = dev_data_q;
        data_d      = data_q;
`ifdef N64_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_request) begin
                    sel_d       = decoded;
                    dev_write_d = bus.i_write;
                    dev_addr_d  = bus.i_address;
                    dev_data_d  = bus.i_data;
`ifdef N64_BUS_TIMEOUT_EN
                    // Loaded with 1 so the accept cycle itself is counted.
                    cnt_d       = CNT_W'(1);
`endif
                    if (|decoded) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESPOND;
                        data_d  = UNMAPPED_READ_DATA;
                    end
                end
            end
            ISSUE: begin
                if (!sel_busy) begin
                    if (sel_ack) begin
                        state_d = RESPOND;
                        if (!dev_write_q) data_d = sel_rdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sel_ack) begin
                    state_d = RESPOND;
                    if (!dev_write_q) data_d = sel_rdata;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef N64_BUS_TIMEOUT_EN
        // A genuine device ack in the same cycle wins over the watchdog.
        if (state_q == ISSUE || state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (state_d != RESPOND && cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d   = RESPOND;
                timeout_d = 1'b1;
                if (!dev_write_q) data_d = TIMEOUT_READ_DATA;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            dev_write_q <= 1'b0;
            dev_addr_q  <= '0;
            dev_data_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dev_write_q <= dev_write_d;
            dev_addr_q  <= dev_addr_d;
            dev_data_q  <= dev_data_d;
            data_q      <= data_d;
        end
    end

`ifdef N64_BUS_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    // timeout_d is only set on the transition into RESPOND, so this pulses
    // exactly with o_ack.
    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_ack            = (state_q == RESPOND);
    assign bus.o_data           = data_q;
    assign bus.o_device_request = (state_q == ISSUE) ? sel_q : '0;
    assign bus.o_device_write   = dev_write_q;
    assign bus.o_device_address = dev_addr_q;
    assign bus.o_device_data    = dev_data_q;

endmodule

// File: tb/tb_n64_bus_router.sv
// tb_n64_bus_router: self-checking bench for n64_bus_router.
// Expected responses are pushed to a scoreboard queue when a transaction is
// driven and popped by a monitor on every o_ack. Scenario tasks add inline
// checks of handshake timing and device-side outputs.
// The timeout scenario is compiled in only with N64_BUS_TIMEOUT_EN.
module tb_n64_bus_router;

    localparam int NB = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    n64_bus_router_if #(.NUM_BANKS(NB)) bus ();

    n64_bus_router #(.NUM_BANKS(NB), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        timeout;
    } exp_t;

    exp_t        exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          ack_count = 0;
    logic [31:0] model_data = 32'h0;

    // Scoreboard monitor: every o_ack must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_timeout === 1'b1 && bus.o_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL timeout_without_ack: o_timeout=1 o_ack=%b, expected o_ack=1", bus.o_ack);
        end
        if (bus.o_ack === 1'b1) begin
            ack_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: o_ack=1 with no transaction pending, o_data=%h", bus.o_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_data !== e.data) begin
                    errors++;
                    $display("FAIL ack_data: o_data=%h expected %h", bus.o_data, e.data);
                end
                checks++;
                if (bus.o_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL ack_timeout_flag: o_timeout=%b expected %b", bus.o_timeout, e.timeout);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: o_busy=%b expected 0 within 60 cycles", bus.o_busy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.o_busy, bus.o_ack, bus.o_timeout, bus.o_device_write} !== 4'b0) begin
            errors++;
            $display("FAIL %s_flags: busy/ack/timeout/write=%b expected 0000", tag,
                     {bus.o_busy, bus.o_ack, bus.o_timeout, bus.o_device_write});
        end
        checks++;
        if (bus.o_data !== 32'h0) begin
            errors++;
            $display("FAIL %s_o_data: got %h expected 0", tag, bus.o_data);
        end
        checks++;
        if (bus.o_device_request !== '0) begin
            errors++;
            $display("FAIL %s_device_request: got %b expected 0", tag, bus.o_device_request);
        end
        checks++;
        if (bus.o_device_address !== 26'h0 || bus.o_device_data !== 32'h0) begin
            errors++;
            $display("FAIL %s_device_addr_data: got %h/%h expected 0/0", tag,
                     bus.o_device_address, bus.o_device_data);
        end
    endtask

    // One complete transaction with a scripted device: busy for busy_cyc
    // ISSUE cycles, then ack ack_dly cycles after acceptance (0 = same cycle).
    task automatic do_txn(input logic wr, input logic [3:0] bank, input logic [25:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int busy_cyc, input int ack_dly);
        int             b;
        logic           mapped;
        logic [NB-1:0]  onehot;
        exp_t           e;
        b      = int'(bank);
        mapped = (b != 0) && (b < NB);
        onehot = '0;
        if (mapped) onehot[b] = 1'b1;
        e.data    = !mapped ? 32'h0 : (wr ? model_data : rdata);
        e.timeout = 1'b0;
        model_data = e.data;

        wait_idle();
        if (mapped) begin
            bus.i_device_data[32*b +: 32] = rdata;
            bus.i_device_busy[b] = (busy_cyc > 0);
        end
        exp_q.push_back(e);
        bus.i_request = 1'b1; bus.i_write = wr; bus.i_bank = bank;
        bus.i_address = addr; bus.i_data = wdata;
        @(negedge clk);
        bus.i_request = 1'b0;

        if (!mapped) begin
            checks++;
            if (bus.o_ack !== 1'b1) begin
                errors++;
                $display("FAIL unmapped_ack_latency bank %0d: o_ack=%b expected 1", b, bus.o_ack);
            end
            checks++;
            if (bus.o_device_request !== '0) begin
                errors++;
                $display("FAIL unmapped_no_request bank %0d: got %b expected 0", b, bus.o_device_request);
            end
        end else begin
            checks++;
            if ({bus.o_device_write, bus.o_device_address, bus.o_device_data} !== {wr, addr, wdata}) begin
                errors++;
                $display("FAIL device_fields: write/addr/data=%b/%h/%h expected %b/%h/%h",
                         bus.o_device_write, bus.o_device_address, bus.o_device_data, wr, addr, wdata);
            end
            repeat (busy_cyc) begin
                checks++;
                if (bus.o_device_request !== onehot) begin
                    errors++;
                    $display("FAIL issue_request_busy: got %b expected %b", bus.o_device_request, onehot);
                end
                @(negedge clk);
            end
            checks++;
            if (bus.o_device_request !== onehot) begin
                errors++;
                $display("FAIL issue_request: got %b expected %b", bus.o_device_request, onehot);
            end
            bus.i_device_busy[b] = 1'b0;
            if (ack_dly == 0) bus.i_device_ack[b] = 1'b1;
            @(negedge clk);
            if (ack_dly > 0) begin
                checks++;
                if (bus.o_device_request !== '0 || bus.o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_state: request=%b busy=%b expected 0/1",
                             bus.o_device_request, bus.o_busy);
                end
                repeat (ack_dly - 1) @(negedge clk);
                bus.i_device_ack[b] = 1'b1;
                @(negedge clk);
            end
            bus.i_device_ack[b] = 1'b0;
            checks++;
            if (bus.o_ack !== 1'b1 || bus.o_device_request !== '0) begin
                errors++;
                $display("FAIL ack_latency: o_ack=%b request=%b expected 1/0", bus.o_ack, bus.o_device_request);
            end
        end
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_write();
        do_txn(1'b0, 4'd1, 26'h0000040, 32'h0, 32'hDEADBEEF, 2, 4);
        checks++;
        if (bus.o_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold: o_data=%h expected deadbeef", bus.o_data);
        end
        do_txn(1'b1, 4'd3, 26'h0000104, 32'h12345678, 32'hBAD0BAD0, 0, 1);
        checks++;
        if (bus.o_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_keeps_data: o_data=%h expected deadbeef", bus.o_data);
        end
    endtask

    task automatic test_unmapped();
        logic [3:0] banks [4];
        banks = '{4'd0, 4'd9, 4'd8, 4'd15};
        foreach (banks[i]) do_txn(1'b0, banks[i], 26'(i), 32'h0, 32'h0BAD_0000, 0, 1);
    endtask

    task automatic test_stray_ack();
        int   acks_before;
        exp_t e;
        wait_idle();
        acks_before = ack_count;
        bus.i_device_ack = '1;
        repeat (2) @(negedge clk);
        bus.i_device_ack = '0;
        @(negedge clk);
        checks++;
        if (ack_count != acks_before) begin
            errors++;
            $display("FAIL idle_ack_ignored: %0d acks expected 0", ack_count - acks_before);
        end

        e.data = 32'h2222_0002; e.timeout = 1'b0;
        model_data = e.data;
        exp_q.push_back(e);
        bus.i_device_data[32*2 +: 32] = 32'h2222_0002;
        bus.i_device_data[32*5 +: 32] = 32'h5555_5555;
        bus.i_device_busy = '0;
        bus.i_request = 1'b1; bus.i_write = 1'b0; bus.i_bank = 4'd2; bus.i_address = 26'h10;
        @(negedge clk);
        bus.i_request = 1'b0;
        @(negedge clk);
        // In WAIT: stray bank-5 ack plus a request that must be ignored.
        bus.i_device_ack[5] = 1'b1;
        bus.i_request = 1'b1; bus.i_bank = 4'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.i_request = 1'b0;
            checks++;
            if (bus.o_ack !== 1'b0) begin
                errors++;
                $display("FAIL stray_ack_ignored cycle %0d: o_ack=%b expected 0", k, bus.o_ack);
            end
        end
        bus.i_device_ack[5] = 1'b0;
        bus.i_device_ack[2] = 1'b1;
        @(negedge clk);
        bus.i_device_ack[2] = 1'b0;
        checks++;
        if (bus.o_ack !== 1'b1) begin
            errors++;
            $display("FAIL bank2_ack: o_ack=%b expected 1", bus.o_ack);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (ack_count != acks_before + 1) begin
            errors++;
            $display("FAIL single_ack: %0d acks expected 1", ack_count - acks_before);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 26'($urandom),
                   $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_mid_reset();
        int acks_before;
        wait_idle();
        bus.i_device_busy = '0;
        bus.i_request = 1'b1; bus.i_write = 1'b0; bus.i_bank = 4'd4;
        bus.i_address = 26'h3ABCDEF; bus.i_data = 32'hCAFEF00D;
        @(negedge clk);
        bus.i_request = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_device_address !== 26'h3ABCDEF) begin
            errors++;
            $display("FAIL pre_reset_wait: busy=%b addr=%h expected 1/3abcdef", bus.o_busy, bus.o_device_address);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 32'h0;
        check_all_zero("mid_reset");
        acks_before = ack_count;
        bus.i_device_ack[4] = 1'b1;
        @(negedge clk);
        bus.i_device_ack[4] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack_count != acks_before) begin
            errors++;
            $display("FAIL ack_after_reset: %0d acks expected 0", ack_count - acks_before);
        end
    endtask

`ifdef N64_BUS_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   k = 0;
        wait_idle();
        e.data = 32'hFFFF_FFFF; e.timeout = 1'b1;
        model_data = e.data;
        exp_q.push_back(e);
        bus.i_device_busy = '0;
        bus.i_request = 1'b1; bus.i_write = 1'b0; bus.i_bank = 4'd7;
        @(negedge clk);
        bus.i_request = 1'b0;
        k = 1;
        while (bus.o_ack !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != TO || bus.o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_latency: ack after %0d cycles timeout=%b, expected %0d cycles and 1",
                     k, bus.o_timeout, TO);
        end
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_drain: %0d outstanding expected 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        bus.i_request = 1'b0; bus.i_write = 1'b0; bus.i_bank = 4'd0;
        bus.i_address = '0; bus.i_data = '0;
        bus.i_device_busy = '0; bus.i_device_ack = '0; bus.i_device_data = '0;
        test_reset();
        test_read_write();
        test_unmapped();
        test_stray_ack();
        test_back_to_back();
        test_mid_reset();
`ifdef N64_BUS_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected to finish");
        $fatal(1, "global timeout");
    end

endmodule
